// File: rtl/ex_squash_queue.sv
// ex_squash_queue
//   In-order result queue between execute and writeback. It can drop a younger
//   suffix of its contents when a squash arrives. Each slot holds a live bit.
//   A squash clears the live bit of every younger entry. Dead entries keep
//   their slot until they reach the head, where they are discarded one per
//   cycle and never shown on the output.
//
//   Age is relative to head_seq_num, the oldest uncommitted sequence number:
//     X is younger than the squash iff
//     (X - head_seq_num) mod 2^n > (squash_seq_num - head_seq_num) mod 2^n
//
//   Ports
//     clk, rst                 clock; asynchronous active-high reset
//     in_val / in_rdy          enqueue handshake (in_seq_num, in_pc, in_wdata,
//                              in_waddr, in_preg, in_wen payload)
//     out_val / out_rdy        dequeue handshake (out_* mirrors in_*)
//     squash_val/_seq_num      squash event; the squashing instruction survives
//     head_seq_num             age reference for squash comparisons
//     count                    number of live entries
//
//   Configuration
//     EX_SQUASH_QUEUE_BYPASS_EN  when defined, an empty queue forwards a valid,
//                                non-squashed input to the output in the same
//                                cycle. The forwarded entry is stored only if
//                                out_rdy is low.
module ex_squash_queue #(
  parameter int p_depth          = 2,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_val,
  output logic                          in_rdy,
  input  logic [p_seq_num_bits-1:0]     in_seq_num,
  input  logic [31:0]                   in_pc,
  input  logic [31:0]                   in_wdata,
  input  logic [4:0]                    in_waddr,
  input  logic [p_phys_addr_bits-1:0]   in_preg,
  input  logic                          in_wen,
  output logic                          out_val,
  input  logic                          out_rdy,
  output logic [p_seq_num_bits-1:0]     out_seq_num,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_wdata,
  output logic [4:0]                    out_waddr,
  output logic [p_phys_addr_bits-1:0]   out_preg,
  output logic                          out_wen,
  input  logic                          squash_val,
  input  logic [p_seq_num_bits-1:0]     squash_seq_num,
  input  logic [p_seq_num_bits-1:0]     head_seq_num,
  output logic [$clog2(p_depth+1)-1:0]  count
);

  localparam int c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_bits = $clog2(p_depth + 1);
  localparam logic [c_ptr_bits-1:0] c_last_ptr = c_ptr_bits'(p_depth - 1);
  localparam logic [c_cnt_bits-1:0] c_full_occ = c_cnt_bits'(p_depth);

  typedef struct packed {
    logic [31:0]                 pc;
    logic [31:0]                 wdata;
    logic [4:0]                  waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic                        wen;
  } payload_t;

  logic [p_seq_num_bits-1:0] seq_mem  [p_depth];
  payload_t                  data_mem [p_depth];
  logic [p_depth-1:0]        live_q;
  logic [p_depth-1:0]        live_nxt;
  logic [p_depth-1:0]        kill_mask;
  logic [c_ptr_bits-1:0]     rd_ptr;
  logic [c_ptr_bits-1:0]     wr_ptr;
  logic [c_cnt_bits-1:0]     occ;       // live + dead slots in use
  logic [c_cnt_bits-1:0]     live_cnt;

  logic head_exists, head_live, head_dead, in_kill, byp_val;
  logic enq_store, deq_store;

  function automatic logic is_younger(input logic [p_seq_num_bits-1:0] seq,
                                      input logic [p_seq_num_bits-1:0] head,
                                      input logic [p_seq_num_bits-1:0] sq);
    logic [p_seq_num_bits-1:0] seq_age;
    logic [p_seq_num_bits-1:0] sq_age;
    seq_age = seq - head;   // modular distance from the oldest instruction
    sq_age  = sq - head;
    return seq_age > sq_age;
  endfunction

  function automatic logic [c_ptr_bits-1:0] ptr_inc(input logic [c_ptr_bits-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    kill_mask = '0;
    for (int i = 0; i < p_depth; i++)
      kill_mask[i] = squash_val && is_younger(seq_mem[i], head_seq_num, squash_seq_num);

    head_exists = (occ != '0);
    // A head being squashed this cycle is masked now and discarded next cycle.
    head_live   = head_exists && live_q[rd_ptr] && !kill_mask[rd_ptr];
    head_dead   = head_exists && !live_q[rd_ptr];
    in_kill     = squash_val && is_younger(in_seq_num, head_seq_num, squash_seq_num);

`ifdef EX_SQUASH_QUEUE_BYPASS_EN
    byp_val = !rst && !head_exists && in_val && !in_kill;
`else
    byp_val = 1'b0;
`endif

    out_val   = head_live || byp_val;
    deq_store = (head_live && out_rdy) || head_dead;
    in_rdy    = (occ != c_full_occ) || deq_store;
    // A squashed input is accepted and dropped. A forwarded input that is
    // consumed in the same cycle never occupies a slot.
    enq_store = in_val && in_rdy && !in_kill && !(byp_val && out_rdy);

    live_nxt = live_q & ~kill_mask;
    if (deq_store) live_nxt[rd_ptr] = 1'b0;
    if (enq_store) live_nxt[wr_ptr] = 1'b1;

    out_seq_num = '0;
    out_pc      = '0;
    out_wdata   = '0;
    out_waddr   = '0;
    out_preg    = '0;
    out_wen     = 1'b0;
    if (byp_val) begin
      out_seq_num = in_seq_num;
      out_pc      = in_pc;
      out_wdata   = in_wdata;
      out_waddr   = in_waddr;
      out_preg    = in_preg;
      out_wen     = in_wen;
    end else if (head_exists) begin
      out_seq_num = seq_mem[rd_ptr];
      out_pc      = data_mem[rd_ptr].pc;
      out_wdata   = data_mem[rd_ptr].wdata;
      out_waddr   = data_mem[rd_ptr].waddr;
      out_preg    = data_mem[rd_ptr].preg;
      out_wen     = data_mem[rd_ptr].wen;
    end

    live_cnt = '0;
    for (int i = 0; i < p_depth; i++)
      live_cnt = live_cnt + c_cnt_bits'(live_q[i]);
    count = live_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      live_q <= '0;
    end else begin
      live_q <= live_nxt;
      if (deq_store) rd_ptr <= ptr_inc(rd_ptr);
      if (enq_store) wr_ptr <= ptr_inc(wr_ptr);
      case ({enq_store, deq_store})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // NOTE: the payload storage has no reset. Occupancy and live bits decide what
  // is visible, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (enq_store) begin
      seq_mem[wr_ptr]  <= in_seq_num;
      data_mem[wr_ptr] <= '{pc: in_pc, wdata: in_wdata, waddr: in_waddr,
                            preg: in_preg, wen: in_wen};
    end
  end

endmodule

// File: doc/ex_squash_queue.md
EX_SQUASH_QUEUE -- requirements
Module: ex_squash_queue

Interface
REQ-001 Parameter p_depth, default 2, number of buffered entries; legal range 1..16, non-power-of-2 allowed.
REQ-002 Parameter p_seq_num_bits, default 5, width of sequence numbers.
REQ-003 Parameter p_phys_addr_bits, default 6, width of physical register address.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_val / in_rdy  input / output  1 / 1  enqueue handshake from execute unit.
REQ-007 in_seq_num  input  p_seq_num_bits  sequence number of incoming result.
REQ-008 in_pc, in_wdata  input  32 each  PC and result data.
REQ-009 in_waddr  input  5  architectural destination; in_preg  input  p_phys_addr_bits  physical destination; in_wen  input  1  write enable.
REQ-010 out_val / out_rdy  output / input  1 / 1  dequeue handshake to writeback; out_seq_num, out_pc, out_wdata, out_waddr, out_preg, out_wen mirror in_* widths.
REQ-011 squash_val  input  1  squash event; squash_seq_num  input  p_seq_num_bits  seq num of squashing instruction (itself survives).
REQ-012 head_seq_num  input  p_seq_num_bits  oldest uncommitted seq num, age reference.
REQ-013 count  output  $clog2(p_depth+1)  number of live entries.

Function
REQ-014 Block SHALL be an in-order circular FIFO; read/write pointers wrap from p_depth-1 to 0.
REQ-015 Enqueue occurs when in_val && in_rdy; dequeue occurs when out_val && out_rdy.
REQ-016 in_rdy SHALL be (live+dead occupancy < p_depth) || (out_val && out_rdy) || head entry dead (same-cycle vacate).
REQ-017 Each entry carries a live bit; out_val SHALL be 1 only when head entry exists, is live, and is not being squashed this cycle.
REQ-018 Age: entry X is younger than squash iff (X - head_seq_num) mod 2^p_seq_num_bits > (squash_seq_num - head_seq_num) mod 2^p_seq_num_bits.
REQ-019 On squash_val, every stored entry younger than squash_seq_num SHALL have its live bit cleared at the next edge; its output is masked combinationally in the same cycle.
REQ-020 An enqueue in the same cycle as a squash that it is younger than SHALL be handshaken (in_rdy honoured) but stored dead or dropped; never presented on out.
REQ-021 A dead head entry SHALL be discarded automatically, one per cycle, without asserting out_val.
REQ-022 count SHALL reflect live entries only; simultaneous enqueue+dequeue leaves count unchanged.
REQ-023 Latency without bypass: accepted entry visible on out no earlier than the following cycle.
REQ-024 Output payload SHALL hold stable while out_val && !out_rdy unless squashed.
REQ-025 Entries SHALL never reorder; squash only removes a younger suffix.

Reset
REQ-026 On rst assertion (any time, including mid-transfer) pointers, occupancy, live bits clear immediately; out_val=0, count=0, in_rdy=1 while rst high; payload outputs 0.
REQ-027 No handshake SHALL complete while rst is high.

Configuration
REQ-028 Macro EX_SQUASH_QUEUE_BYPASS_EN: when defined, an empty queue SHALL forward a valid, non-squashed input to out in the same cycle (zero latency); if out_rdy the entry is not stored, else it is stored normally.
REQ-029 Without EX_SQUASH_QUEUE_BYPASS_EN, out is driven only from storage; latency is exactly 1 cycle when empty.

Verification
REQ-030 p_depth=3: enqueue seq 1,2,3 with out_rdy=0 -> in_rdy=0, count=3; then out_rdy=1 -> drains 1,2,3 in order, one per cycle.
REQ-031 Full queue, in_val and out_rdy same cycle -> both handshakes complete, count stays 3, order preserved.
REQ-032 head_seq_num=30, entries 30,31,0,1 (p_depth=4), squash_seq_num=31 -> entries 0,1 dropped, only 30,31 output, count=2 next cycle.
REQ-033 Squash seq 5 while enqueuing seq 6 -> seq 6 never appears on out; queue empty entries unaffected.
REQ-034 Assert rst with 2 entries mid-drain -> out_val=0, count=0 immediately; after release, new enqueue seq 9 output correctly.
REQ-035 With EX_SQUASH_QUEUE_BYPASS_EN, empty queue, in_val seq 4, out_rdy=1 -> out_val=1, out_seq_num=4 same cycle, count stays 0; without macro -> out_val next cycle.
